// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS32 constants, saturating-counter helpers and BTB entry type
package mips_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    // R-type funct codes
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2a;

    // Counters are carried at the widest supported width; callers truncate.
    localparam int CTR_MAX_BITS = 4;
    // Index is at least 2 bits, so a tag never exceeds 28 bits.
    localparam int TAG_MAX_BITS = 28;

    typedef logic [CTR_MAX_BITS-1:0] ctr_t;

    typedef struct packed {
        logic                    valid;
        logic [TAG_MAX_BITS-1:0] tag;
        logic [31:0]             target;
    } btb_entry_t;

    function automatic ctr_t ctr_max(input int width);
        return ctr_t'((1 << width) - 1);
    endfunction

    function automatic ctr_t weak_taken(input int width);
        return ctr_t'(1 << (width - 1));
    endfunction

    function automatic ctr_t weak_not_taken(input int width);
        return ctr_t'((1 << (width - 1)) - 1);
    endfunction

    function automatic ctr_t sat_inc(input ctr_t ctr, input int width);
        return (ctr >= ctr_max(width)) ? ctr : ctr + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t ctr, input int width);
        return (ctr == '0) ? ctr : ctr - ctr_t'(1);
    endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// rtl/bp_sat_counter_table.sv - ENTRIES x CTR_BITS saturating counter table
// Ports: CLK/RST (sync, active-high); rd_idx -> rd_ctr async read;
//        wr_en/wr_idx/wr_alloc/wr_taken read-modify-write update.
// wr_alloc=1 loads the weak state matching wr_taken instead of stepping.
module bp_sat_counter_table
    import mips_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int IDX_BITS = $clog2(ENTRIES)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_alloc,
    input  logic                wr_taken
);

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];

    assign rd_ctr = ctr_q[rd_idx];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_BITS'(weak_not_taken(CTR_BITS));
            end
        end else if (wr_en) begin
            if (wr_alloc) begin
                ctr_q[wr_idx] <= wr_taken ? CTR_BITS'(weak_taken(CTR_BITS))
                                          : CTR_BITS'(weak_not_taken(CTR_BITS));
            end else if (wr_taken) begin
                ctr_q[wr_idx] <= CTR_BITS'(sat_inc(ctr_t'(ctr_q[wr_idx]), CTR_BITS));
            end else begin
                ctr_q[wr_idx] <= CTR_BITS'(sat_dec(ctr_t'(ctr_q[wr_idx]), CTR_BITS));
            end
        end
    end

endmodule

// File: rtl/mips_branch_predictor.sv
// rtl/mips_branch_predictor.sv - tagged BTB plus saturating-counter branch predictor
// Ports: CLK, RST (sync, active-high); fetch_pc -> pred_taken/pred_target
//        (combinational lookup); upd_valid/upd_pc/upd_taken/upd_target/
//        upd_mispredict resolve-time update; mispredict_cnt saturating stat.
// Optional macro BP_GSHARE_EN: counters indexed by btb_idx XOR global history.
module mips_branch_predictor
    import mips_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int TAG_BITS = 8,
    parameter int CNT_BITS = 32
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [31:0]         fetch_pc,
    output logic                pred_taken,
    output logic [31:0]         pred_target,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_taken,
    input  logic [31:0]         upd_target,
    input  logic                upd_mispredict,
    output logic [CNT_BITS-1:0] mispredict_cnt
);

    localparam int IDX_BITS = $clog2(ENTRIES);

    btb_entry_t btb_q [ENTRIES];

    logic [IDX_BITS-1:0]     f_idx, u_idx, f_ctr_idx, u_ctr_idx;
    logic [TAG_MAX_BITS-1:0] f_tag, u_tag;
    logic                    f_hit, u_hit;
    logic [CTR_BITS-1:0]     f_ctr;
    logic                    unused_pc_bits;

    // Word-offset and above-tag PC bits carry no index/tag information.
    assign unused_pc_bits = ^{fetch_pc, upd_pc};

    assign f_idx = fetch_pc[IDX_BITS+1:2];
    assign u_idx = upd_pc[IDX_BITS+1:2];
    assign f_tag = TAG_MAX_BITS'(fetch_pc[IDX_BITS+2 +: TAG_BITS]);
    assign u_tag = TAG_MAX_BITS'(upd_pc[IDX_BITS+2 +: TAG_BITS]);

    assign f_hit = btb_q[f_idx].valid && (btb_q[f_idx].tag == f_tag);
    assign u_hit = btb_q[u_idx].valid && (btb_q[u_idx].tag == u_tag);

`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_q;

    // Lookup and update both hash with the history held before this edge.
    assign f_ctr_idx = f_idx ^ ghr_q;
    assign u_ctr_idx = u_idx ^ ghr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ghr_q <= '0;
        end else if (upd_valid) begin
            ghr_q <= {ghr_q[IDX_BITS-2:0], upd_taken};
        end
    end
`else
    assign f_ctr_idx = f_idx;
    assign u_ctr_idx = u_idx;
`endif

    bp_sat_counter_table #(
        .ENTRIES  (ENTRIES),
        .CTR_BITS (CTR_BITS),
        .IDX_BITS (IDX_BITS)
    ) u_ctr_table (
        .CLK      (CLK),
        .RST      (RST),
        .rd_idx   (f_ctr_idx),
        .rd_ctr   (f_ctr),
        .wr_en    (upd_valid),
        .wr_idx   (u_ctr_idx),
        .wr_alloc (!u_hit),
        .wr_taken (upd_taken)
    );

    // No bypass: a same-cycle update only becomes visible after the edge.
    assign pred_taken  = f_hit && f_ctr[CTR_BITS-1];
    assign pred_target = pred_taken ? btb_q[f_idx].target : 32'h0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_q[i] <= '0;
            end
        end else if (upd_valid) begin
            if (!u_hit) begin
                btb_q[u_idx].valid  <= 1'b1;
                btb_q[u_idx].tag    <= u_tag;
                btb_q[u_idx].target <= upd_target;
            end else if (upd_taken) begin
                btb_q[u_idx].target <= upd_target;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mispredict_cnt <= '0;
        end else if (upd_valid && upd_mispredict && (mispredict_cnt != '1)) begin
            mispredict_cnt <= mispredict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mips_branch_predictor.sv
// tb/tb_mips_branch_predictor.sv - self-checking bench for mips_branch_predictor
module tb_mips_branch_predictor;

    localparam int ENTRIES  = 64;
    localparam int CTR_BITS = 2;
    localparam int TAG_BITS = 8;
    localparam int CNT_BITS = 4;
    localparam int CTR_TOP  = (1 << CTR_BITS) - 1;
    localparam int CTR_MID  = 1 << (CTR_BITS - 1);
    localparam int CNT_TOP  = (1 << CNT_BITS) - 1;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic [31:0]         fetch_pc = '0;
    logic                pred_taken;
    logic [31:0]         pred_target;
    logic                upd_valid = 1'b0;
    logic [31:0]         upd_pc = '0;
    logic                upd_taken = 1'b0;
    logic [31:0]         upd_target = '0;
    logic                upd_mispredict = 1'b0;
    logic [CNT_BITS-1:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: one record per table slot, counters as plain ints.
    bit          m_valid [ENTRIES];
    int          m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    int          m_cnt;
    int          m_ghr;

    mips_branch_predictor #(
        .ENTRIES  (ENTRIES),
        .CTR_BITS (CTR_BITS),
        .TAG_BITS (TAG_BITS),
        .CNT_BITS (CNT_BITS)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int m_tagof(input logic [31:0] pc);
        return int'((pc >> 8) % (1 << TAG_BITS));
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tagof(pc));
    endfunction

    function automatic int m_slot(input logic [31:0] pc);
`ifdef BP_GSHARE_EN
        return m_idx(pc) ^ m_ghr;
`else
        return m_idx(pc);
`endif
    endfunction

    function automatic bit exp_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_slot(pc)] >= CTR_MID);
    endfunction

    function automatic logic [31:0] exp_target(input logic [31:0] pc);
        return exp_taken(pc) ? m_tgt[m_idx(pc)] : 32'h0;
    endfunction

    task automatic model_clock();
        int i, s;
        if (RST) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = '0; m_ctr[k] = CTR_MID - 1;
            end
            m_cnt = 0;
            m_ghr = 0;
        end else if (upd_valid) begin
            i = m_idx(upd_pc);
            s = m_slot(upd_pc);
            if (m_hit(upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[s] = (m_ctr[s] < CTR_TOP) ? m_ctr[s] + 1 : CTR_TOP;
                    m_tgt[i] = upd_target;
                end else begin
                    m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
                end
            end else begin
                m_valid[i] = 1;
                m_tag[i]   = m_tagof(upd_pc);
                m_tgt[i]   = upd_target;
                m_ctr[s]   = upd_taken ? CTR_MID : CTR_MID - 1;
            end
            if (upd_mispredict) m_cnt = (m_cnt < CNT_TOP) ? m_cnt + 1 : CNT_TOP;
            m_ghr = ((m_ghr << 1) | int'(upd_taken)) % ENTRIES;
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit t,
                         input logic [31:0] tgt, input bit mis, input logic [31:0] lpc);
        upd_valid = v; upd_pc = pc; upd_taken = t; upd_target = tgt;
        upd_mispredict = mis; fetch_pc = lpc;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_clock();
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        drive(1, 32'h40, 1, 32'h100, 1, 32'h40);
        tick();
        tick();
        RST = 1'b0;
        drive(0, 32'h0, 0, 32'h0, 0, 32'h40);
        @(negedge CLK);
        checks++;
        if (pred_taken !== 1'b0) begin
            errors++; $display("FAIL reset_taken got %0b want 0", pred_taken);
        end
        checks++;
        if (pred_target !== 32'h0) begin
            errors++; $display("FAIL reset_target got %h want 0", pred_target);
        end
        checks++;
        if (mispredict_cnt !== '0) begin
            errors++; $display("FAIL reset_cnt got %0d want 0", mispredict_cnt);
        end
        tick();
    endtask

    task automatic test_counter();
        // {valid, taken, target}: allocate, idle, 3 taken, 3 not-taken, idle
        bit          sv [9] = '{1, 0, 1, 1, 1, 1, 1, 1, 0};
        bit          st [9] = '{1, 0, 1, 1, 1, 0, 0, 0, 0};
        logic [31:0] sg [9] = '{32'h100, 0, 32'h100, 32'h100, 32'h100, 0, 0, 0, 0};
        for (int n = 0; n < 9; n++) begin
            drive(sv[n], 32'h40, st[n], sg[n], 0, 32'h40);
            @(negedge CLK);
            checks++;
            if (pred_taken !== exp_taken(32'h40)) begin
                errors++; $display("FAIL ctr_taken step %0d got %0b want %0b", n, pred_taken, exp_taken(32'h40));
            end
            checks++;
            if (pred_target !== exp_target(32'h40)) begin
                errors++; $display("FAIL ctr_target step %0d got %h want %h", n, pred_target, exp_target(32'h40));
            end
            tick();
        end
    endtask

    task automatic test_same_cycle();
        for (int n = 0; n < 2; n++) begin
            drive(n == 0, 32'h40, 1, 32'h104, 0, 32'h40);
            @(negedge CLK);
            checks++;
            if (pred_taken !== exp_taken(32'h40)) begin
                errors++; $display("FAIL same_cycle_taken step %0d got %0b want %0b", n, pred_taken, exp_taken(32'h40));
            end
            checks++;
            if (pred_target !== exp_target(32'h40)) begin
                errors++; $display("FAIL same_cycle_target step %0d got %h want %h", n, pred_target, exp_target(32'h40));
            end
            tick();
        end
    endtask

    task automatic test_alias();
        logic [31:0] lk [3] = '{32'h40, 32'h40, 32'h140};
        for (int n = 0; n < 3; n++) begin
            drive(n == 0, 32'h140, 1, 32'h200, 0, lk[n]);
            @(negedge CLK);
            checks++;
            if (pred_taken !== exp_taken(lk[n])) begin
                errors++; $display("FAIL alias_taken pc %h got %0b want %0b", lk[n], pred_taken, exp_taken(lk[n]));
            end
            checks++;
            if (pred_target !== exp_target(lk[n])) begin
                errors++; $display("FAIL alias_target pc %h got %h want %h", lk[n], pred_target, exp_target(lk[n]));
            end
            tick();
        end
    endtask

    task automatic test_mispredict_sat();
        // A mispredict flag without upd_valid must not count.
        drive(0, 32'h80, 1, 32'h300, 1, 32'h80);
        tick();
        for (int n = 0; n < 20; n++) begin
            drive(1, {22'h0, 4'($urandom_range(0, 15)), 6'h0}, 1'($urandom), $urandom, 1, 32'h40);
            tick();
            @(negedge CLK);
            checks++;
            if (mispredict_cnt !== CNT_BITS'(m_cnt)) begin
                errors++; $display("FAIL mis_cnt step %0d got %0d want %0d", n, mispredict_cnt, m_cnt);
            end
        end
        checks++;
        if (mispredict_cnt !== CNT_BITS'(CNT_TOP)) begin
            errors++; $display("FAIL mis_cnt_saturated got %0d want %0d", mispredict_cnt, CNT_TOP);
        end
    endtask

    task automatic test_reset_mid();
        RST = 1'b1;
        drive(1, 32'h40, 1, 32'h500, 1, 32'h40);
        tick();
        RST = 1'b0;
        for (int n = 0; n < 2; n++) begin
            drive(0, 32'h0, 0, 32'h0, 0, n == 0 ? 32'h40 : 32'h140);
            @(negedge CLK);
            checks++;
            if (pred_taken !== 1'b0) begin
                errors++; $display("FAIL reset_mid_taken pc %h got %0b want 0", fetch_pc, pred_taken);
            end
            checks++;
            if (mispredict_cnt !== '0) begin
                errors++; $display("FAIL reset_mid_cnt got %0d want 0", mispredict_cnt);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [31:0] pc, lpc;
        for (int n = 0; n < 400; n++) begin
            pc  = {20'h0, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'b0, 2'b00};
            lpc = ($urandom_range(0, 1) == 0) ? pc
                : {20'h0, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 3'($urandom_range(0, 7)), 1'b0, 2'b00};
            RST = ($urandom_range(0, 79) == 0);
            drive($urandom_range(0, 3) != 0, pc, 1'($urandom), $urandom, 1'($urandom), lpc);
            @(negedge CLK);
            checks++;
            if (pred_taken !== exp_taken(lpc)) begin
                errors++; $display("FAIL rand_taken cyc %0d pc %h got %0b want %0b", n, lpc, pred_taken, exp_taken(lpc));
            end
            checks++;
            if (pred_target !== exp_target(lpc)) begin
                errors++; $display("FAIL rand_target cyc %0d pc %h got %h want %h", n, lpc, pred_target, exp_target(lpc));
            end
            checks++;
            if (mispredict_cnt !== CNT_BITS'(m_cnt)) begin
                errors++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", n, mispredict_cnt, m_cnt);
            end
            tick();
        end
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_counter();
        test_same_cycle();
        test_alias();
        test_mispredict_sat();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
